// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared state and mode encodings for the N:1 scan selector
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAN  = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/scan_ctr.sv
// rtl/scan_ctr.sv - dwell and channel counters for auto-scan round-robin
module scan_ctr #(
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  localparam int SW      = $clog2(CHANNELS),
  localparam int DW      = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv_en,
  output logic [SW-1:0] ch,
  output logic          wrap_nxt
);

  // ch/dcnt name the sample that the next scanning edge will emit;
  // wrap_nxt marks that this sample is the first one after a wrap.
  logic [DW-1:0] dcnt;
  logic          dwell_end;
  logic          last_ch;

  assign dwell_end = (dcnt == DW'(DWELL - 1));
  assign last_ch   = (ch == SW'(CHANNELS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt     <= '0;
      ch       <= '0;
      wrap_nxt <= 1'b0;
    end else if (clr) begin
      dcnt     <= '0;
      ch       <= '0;
      wrap_nxt <= 1'b0;
    end else if (adv_en) begin
      if (dwell_end) begin
        dcnt     <= '0;
        ch       <= last_ch ? '0 : ch + 1'b1;
        wrap_nxt <= last_ch;
      end else begin
        dcnt     <= dcnt + 1'b1;
        wrap_nxt <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - registered N:1 channel selector with manual and auto-scan modes
module mux_scan_n
  import mux_scan_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  localparam int SW      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SW-1:0]             sel,
  input  logic                      mode,
  input  logic                      en,
  output logic [WIDTH-1:0]          dout,
  output logic [SW-1:0]             dout_ch,
  output logic                      dout_vld,
  output logic                      wrap
);

  state_t          state;
  state_t          state_nxt;
  logic [SW-1:0]   scan_ch;
  logic            scan_wrap;
  logic            sel_ok;
  logic            load;
  logic            wrap_d;
  logic [SW-1:0]   ch_pick;
  logic [WIDTH-1:0] data_pick;

  assign sel_ok = (int'(sel) < CHANNELS);

  // Counters stay cleared outside SCAN so every entry restarts at channel 0.
  scan_ctr #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_scan_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_nxt != SCAN),
    .adv_en   (state_nxt == SCAN),
    .ch       (scan_ch),
    .wrap_nxt (scan_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    wrap_d    = 1'b0;
    ch_pick   = dout_ch;
    if (!en)                    state_nxt = IDLE;
    else if (mode == MODE_SCAN) state_nxt = SCAN;
    else                        state_nxt = MAN;
    case (state_nxt)
      MAN: begin
        if (sel_ok) begin
          load    = 1'b1;
          ch_pick = sel;
        end
      end
      SCAN: begin
        load    = 1'b1;
        ch_pick = scan_ch;
        wrap_d  = scan_wrap;
      end
      default: ;
    endcase
  end

  // ch_pick is always in range: out-of-range sel falls back to dout_ch.
  assign data_pick = din[int'(ch_pick)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_ch  <= '0;
      dout_vld <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      dout_vld <= load;
      wrap     <= wrap_d;
      if (load) begin
        dout    <= data_pick;
        dout_ch <= ch_pick;
      end
    end
  end

endmodule
